buspirate_top: RTL and testbench

BUSPIRATE_TOP -- requirements
Module: buspirate_top

---
 rtl/buspirate_pkg.sv | 30 +++
 rtl/buspirate_top_fifo_sync.sv | 55 +++++
 rtl/buspirate_top.sv | 227 ++++++++++++++++++++++
 tb/tb_buspirate_top.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/buspirate_pkg.sv
// Shared definitions for the Bus Pirate FPGA core: register map, CTRL/status
// bit positions and the logic-analyser state encoding.
package buspirate_pkg;

  localparam logic [7:0] ADDR_DATA     = 8'h00;
  localparam logic [7:0] ADDR_CTRL     = 8'h02;
  localparam logic [7:0] ADDR_LA_COUNT = 8'h04;
  localparam logic [7:0] ADDR_LAT      = 8'h06;
  localparam logic [7:0] ADDR_PIN_OUT  = 8'h10;
  localparam logic [7:0] ADDR_PIN_DIR  = 8'h11;
  localparam logic [7:0] ADDR_PIN_OD   = 8'h12;
  localparam logic [7:0] ADDR_PWM_HI   = 8'h19;
  localparam logic [7:0] ADDR_PWM_LO   = 8'h1a;

  localparam int CTRL_SRAM_CS    = 0;
  localparam int CTRL_SRAM_DRIVE = 1;
  localparam int CTRL_LA_START   = 3;

  localparam int ST_LA_BUSY    = 8;
  localparam int ST_LA_DONE    = 9;
  localparam int ST_FIFO_FULL  = 10;
  localparam int ST_FIFO_EMPTY = 11;

  typedef enum logic [1:0] {
    LA_IDLE    = 2'd0,
    LA_CAPTURE = 2'd1,
    LA_DONE    = 2'd2
  } la_state_t;

endpackage

// File: rtl/buspirate_top_fifo_sync.sv
// Small synchronous show-ahead FIFO; pushes when full and pops when empty
// are silently dropped.
module fifo_sync #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push, do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr_reg];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/buspirate_top.sv
// Bus Pirate FPGA core: asynchronous MCU register bus, TX FIFO, SRAM logic
// analyser capture, buffered IO pins and a PWM generator on pin 0.
module buspirate_top
  import buspirate_pkg::*;
#(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int LA_WIDTH      = 8,
  parameter int LA_CHIPS      = 2,
  parameter int BP_PINS       = 5,
  parameter int FIFO_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clock_master,
  input  logic                     reset,
  inout  wire  [BP_PINS-1:0]       bpio_io,
  output logic [BP_PINS-1:0]       bpio_dir,
  output logic [BP_PINS-1:0]       bpio_od,
  output logic [LA_CHIPS-1:0]      sram_clock,
  output logic [LA_CHIPS-1:0]      sram_cs,
  inout  wire  [LA_WIDTH-1:0]      sram_sio,
  output logic                     lat_oe,
  input  logic [LA_WIDTH-1:0]      lat,
  input  logic                     mcu_clock,
  input  logic                     mcu_mosi,
  output logic                     mcu_miso,
  input  logic                     mc_oe,
  input  logic                     mc_ce,
  input  logic                     mc_we,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  inout  wire  [MC_DATA_WIDTH-1:0] mc_data
);

  localparam int DW = MC_DATA_WIDTH;

  // Bit [1] is the synchronised strobe, bit [2] its previous value for edges.
  logic [2:0] oe_sync_reg, we_sync_reg, ce_sync_reg;
  logic       wr_stb, rd_fall;
  logic [7:0] addr8;
  logic [DW-1:0] wr_data;

  logic [7:0]         ctrl_reg;
  logic [DW-1:0]      la_count_reg, la_cnt_reg;
  logic [BP_PINS-1:0] pin_out_reg, pin_dir_reg, pin_od_reg, pin_val;
  logic [BP_PINS-1:0] bpio_s1_reg, bpio_s2_reg;
  logic [DW-1:0]      pwm_hi_reg, pwm_lo_reg, pwm_cnt_reg;
  logic               pwm_high_reg, pwm_en;
  logic [DW-1:0]      rdata_reg, rd_next;
  logic               sram_clk_reg;

  la_state_t la_state_reg, la_state_next;
  logic      ctrl_wr, la_start;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FIFO_WIDTH-1:0] fifo_dout, fifo_head;
  logic [15:0]           status_word;

  logic unused_mcu;
  assign unused_mcu = mcu_clock ^ mcu_mosi;

  always_ff @(posedge clock_master) begin
    if (reset) begin
      oe_sync_reg <= 3'b111;
      we_sync_reg <= 3'b111;
      ce_sync_reg <= 3'b111;
      bpio_s1_reg <= '0;
      bpio_s2_reg <= '0;
    end else begin
      oe_sync_reg <= {oe_sync_reg[1:0], mc_oe};
      we_sync_reg <= {we_sync_reg[1:0], mc_we};
      ce_sync_reg <= {ce_sync_reg[1:0], mc_ce};
      bpio_s1_reg <= bpio_io;
      bpio_s2_reg <= bpio_s1_reg;
    end
  end

  assign addr8    = 8'(mc_add);
  assign wr_data  = mc_data;
  assign wr_stb   = we_sync_reg[1] && !we_sync_reg[2] && !ce_sync_reg[1];
  assign rd_fall  = !oe_sync_reg[1] && oe_sync_reg[2] && !ce_sync_reg[1];
  assign ctrl_wr  = wr_stb && (addr8 == ADDR_CTRL);
  assign la_start = ctrl_wr && wr_data[CTRL_LA_START] && (la_count_reg != '0);

  always_ff @(posedge clock_master) begin
    if (reset) begin
      ctrl_reg     <= '0;
      la_count_reg <= '0;
      pin_out_reg  <= '0;
      pin_dir_reg  <= '0;
      pin_od_reg   <= '0;
      pwm_hi_reg   <= '0;
      pwm_lo_reg   <= '0;
    end else if (wr_stb) begin
      case (addr8)
        ADDR_CTRL: begin
          ctrl_reg                <= wr_data[7:0];
          ctrl_reg[CTRL_LA_START] <= 1'b0;
        end
        ADDR_LA_COUNT: la_count_reg <= wr_data;
        ADDR_PIN_OUT:  pin_out_reg  <= wr_data[BP_PINS-1:0];
        ADDR_PIN_DIR:  pin_dir_reg  <= wr_data[BP_PINS-1:0];
        ADDR_PIN_OD:   pin_od_reg   <= wr_data[BP_PINS-1:0];
        ADDR_PWM_HI:   pwm_hi_reg   <= wr_data;
        ADDR_PWM_LO:   pwm_lo_reg   <= wr_data;
        default: ;
      endcase
    end
  end

  assign fifo_push = wr_stb && (addr8 == ADDR_DATA);
  assign fifo_pop  = rd_fall && (addr8 == ADDR_DATA) && !ctrl_reg[CTRL_SRAM_CS] && !fifo_empty;
  assign fifo_head = fifo_empty ? '0 : fifo_dout;

  fifo_sync #(
    .WIDTH(FIFO_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clock_master),
    .rst  (reset),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (FIFO_WIDTH'(wr_data)),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clock_master) begin
    if (reset) la_state_reg <= LA_IDLE;
    else       la_state_reg <= la_state_next;
  end

  always_comb begin
    la_state_next = la_state_reg;
    case (la_state_reg)
      LA_IDLE:    if (la_start) la_state_next = LA_CAPTURE;
      // Leave on the falling half of the last sample so the clock idles low.
      LA_CAPTURE: if (sram_clk_reg && la_cnt_reg == '0) la_state_next = LA_DONE;
      LA_DONE:    if (ctrl_wr) la_state_next = la_start ? LA_CAPTURE : LA_IDLE;
      default:    la_state_next = LA_IDLE;
    endcase
  end

  always_ff @(posedge clock_master) begin
    if (reset) begin
      la_cnt_reg   <= '0;
      sram_clk_reg <= 1'b0;
    end else if (la_state_reg != LA_CAPTURE && la_state_next == LA_CAPTURE) begin
      la_cnt_reg   <= la_count_reg;
      sram_clk_reg <= 1'b0;
    end else if (la_state_reg == LA_CAPTURE) begin
      sram_clk_reg <= !sram_clk_reg;
      if (!sram_clk_reg) la_cnt_reg <= la_cnt_reg - 1'b1;
    end else begin
      sram_clk_reg <= rd_fall && (addr8 == ADDR_DATA) && ctrl_reg[CTRL_SRAM_CS];
    end
  end

  assign sram_clock = {LA_CHIPS{sram_clk_reg}};
  assign sram_cs    = (la_state_reg == LA_CAPTURE || ctrl_reg[CTRL_SRAM_CS]) ?
                      {LA_CHIPS{1'b0}} : {LA_CHIPS{1'b1}};
  assign sram_sio   = (la_state_reg != LA_CAPTURE && ctrl_reg[CTRL_SRAM_DRIVE]) ?
                      fifo_head[LA_WIDTH-1:0] : {LA_WIDTH{1'bz}};
  assign lat_oe     = (la_state_reg == LA_CAPTURE);
  assign mcu_miso   = (la_state_reg == LA_DONE);

  assign pwm_en = (pwm_hi_reg != '0) && (pwm_lo_reg != '0);

  always_ff @(posedge clock_master) begin
    if (reset) begin
      pwm_cnt_reg  <= '0;
      pwm_high_reg <= 1'b1;
    end else if (wr_stb && (addr8 == ADDR_PWM_HI || addr8 == ADDR_PWM_LO)) begin
      pwm_cnt_reg  <= '0;
      pwm_high_reg <= 1'b1;
    end else if (pwm_en) begin
      if (pwm_cnt_reg == (pwm_high_reg ? pwm_hi_reg : pwm_lo_reg) - 1'b1) begin
        pwm_cnt_reg  <= '0;
        pwm_high_reg <= !pwm_high_reg;
      end else begin
        pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    pin_val    = pin_out_reg;
    pin_val[0] = pwm_en ? pwm_high_reg : pin_out_reg[0];
  end

  assign bpio_dir = pin_dir_reg;
  assign bpio_od  = pin_od_reg;

  for (genvar gi = 0; gi < BP_PINS; gi++) begin : g_pin
    // Open-drain pins only ever pull low; a 1 releases the line.
    assign bpio_io[gi] = (pin_dir_reg[gi] && !(pin_od_reg[gi] && pin_val[gi])) ?
                         pin_val[gi] : 1'bz;
  end

  assign status_word = {4'h0, fifo_empty, fifo_full, la_state_reg == LA_DONE,
                        la_state_reg == LA_CAPTURE, ctrl_reg};

  always_comb begin
    rd_next = '0;
    case (addr8)
      ADDR_DATA:     rd_next = ctrl_reg[CTRL_SRAM_CS] ? DW'(sram_sio) : DW'(fifo_head);
      ADDR_CTRL:     rd_next = DW'(status_word);
      ADDR_LA_COUNT: rd_next = la_count_reg;
      ADDR_LAT:      rd_next = DW'(lat);
      ADDR_PIN_OUT:  rd_next = DW'(bpio_s2_reg);
      ADDR_PIN_DIR:  rd_next = DW'(pin_dir_reg);
      ADDR_PIN_OD:   rd_next = DW'(pin_od_reg);
      ADDR_PWM_HI:   rd_next = pwm_hi_reg;
      ADDR_PWM_LO:   rd_next = pwm_lo_reg;
      default:       rd_next = '0;
    endcase
  end

  // Frozen while a read is in progress so the pre-pop FIFO head stays on the bus.
  always_ff @(posedge clock_master) begin
    if (reset)               rdata_reg <= '0;
    else if (oe_sync_reg[1]) rdata_reg <= rd_next;
  end

  assign mc_data = (!mc_ce && !mc_oe) ? rdata_reg : {DW{1'bz}};

endmodule

// File: tb/tb_buspirate_top.sv
// Randomised scoreboard bench for buspirate_top: bus transactions push
// expectations from a queue-based model, a negedge monitor drains and compares.
module tb_buspirate_top;

  localparam int SEL_DATA = 0, SEL_CS = 1, SEL_SCLK = 2, SEL_LATOE = 3, SEL_MISO = 4;
  localparam int SEL_DIR = 5, SEL_OD = 6, SEL_IO = 7, SEL_SIO = 8, SEL_VAL = 99;

  logic        clk = 1'b0;
  logic        rst;
  wire  [4:0]  bpio_io;
  logic [4:0]  bpio_dir, bpio_od;
  logic [1:0]  sram_clock, sram_cs;
  wire  [7:0]  sram_sio;
  logic        lat_oe;
  logic [7:0]  lat;
  logic        mcu_clock, mcu_mosi, mcu_miso;
  logic        mc_oe, mc_ce, mc_we;
  logic [5:0]  mc_add;
  wire  [15:0] mc_data;

  logic [15:0] tb_data;
  logic        tb_data_en;
  logic [7:0]  tb_sio;
  logic        tb_sio_en;
  logic        mon_req;

  assign mc_data  = tb_data_en ? tb_data : 16'hzzzz;
  assign sram_sio = tb_sio_en ? tb_sio : 8'hzz;

  always #5 clk = ~clk;

  buspirate_top dut (
    .clock_master(clk),
    .reset       (rst),
    .bpio_io     (bpio_io),
    .bpio_dir    (bpio_dir),
    .bpio_od     (bpio_od),
    .sram_clock  (sram_clock),
    .sram_cs     (sram_cs),
    .sram_sio    (sram_sio),
    .lat_oe      (lat_oe),
    .lat         (lat),
    .mcu_clock   (mcu_clock),
    .mcu_mosi    (mcu_mosi),
    .mcu_miso    (mcu_miso),
    .mc_oe       (mc_oe),
    .mc_ce       (mc_ce),
    .mc_we       (mc_we),
    .mc_add      (mc_add),
    .mc_data     (mc_data)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
    logic [31:0] act;
    logic [31:0] mask;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  failures = 0;

  // Free-running SRAM clock observers; the stimulus side takes deltas.
  int rise_cnt = 0, high_cyc = 0, oe_gap = 0;
  always @(posedge sram_clock[0]) rise_cnt++;
  always @(negedge clk) begin
    if (sram_clock[0]) high_cyc++;
    if (sram_clock[0] && !lat_oe) oe_gap++;
  end

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      SEL_DATA:  return 32'(mc_data);
      SEL_CS:    return 32'(sram_cs);
      SEL_SCLK:  return 32'(sram_clock);
      SEL_LATOE: return 32'(lat_oe);
      SEL_MISO:  return 32'(mcu_miso);
      SEL_DIR:   return 32'(bpio_dir);
      SEL_OD:    return 32'(bpio_od);
      SEL_IO:    return 32'(bpio_io);
      SEL_SIO:   return 32'(sram_sio);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  always @(negedge clk) begin
    sb_t         e;
    logic [31:0] act;
    if (mon_req) begin
      while (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        act = (e.sel == SEL_VAL) ? e.act : probe(e.sel);
        checks++;
        if ((act & e.mask) !== (e.exp & e.mask)) begin
          failures++;
          $display("FAIL %s: got 0x%0h expected 0x%0h (mask 0x%0h)", e.name, act & e.mask,
                   e.exp & e.mask, e.mask);
        end else begin
          $display("ok   %s: 0x%0h", e.name, act & e.mask);
        end
      end
    end
  end

  // Reference model state.
  logic [15:0] fifo_m[$];
  logic [7:0]  ctrl_m;
  logic        done_m;

  function automatic logic [15:0] status_m();
    return {4'h0, fifo_m.size() == 0, fifo_m.size() == 4, done_m, 1'b0, ctrl_m};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_sig(input string nm, input int sel, input logic [31:0] exp,
                            input logic [31:0] mask);
    sb_q.push_back('{nm, sel, exp, 32'h0, mask});
  endtask

  task automatic expect_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    sb_q.push_back('{nm, SEL_VAL, exp, act, 32'hffff_ffff});
  endtask

  task automatic sample();
    mon_req = 1'b1;
    tick(1);
    mon_req = 1'b0;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [15:0] d);
    mc_add = a; tb_data = d; tb_data_en = 1'b1; mc_ce = 1'b0;
    tick(2);
    mc_we = 1'b0;
    tick(4);
    mc_we = 1'b1;
    tick(4);
    mc_ce = 1'b1; tb_data_en = 1'b0;
    tick(2);
  endtask

  task automatic bus_read(input logic [5:0] a, input logic [15:0] exp, input string nm);
    mc_add = a; mc_ce = 1'b0;
    tick(4);
    mc_oe = 1'b0;
    tick(5);
    expect_sig(nm, SEL_DATA, 32'(exp), 32'h0000_ffff);
    sample();
    mc_oe = 1'b1;
    tick(1);
    mc_ce = 1'b1;
    tick(3);
  endtask

  task automatic push_data(input logic [15:0] d);
    bus_write(6'h00, d);
    if (fifo_m.size() < 4) fifo_m.push_back(d);
  endtask

  task automatic read_data(input string nm);
    logic [15:0] e;
    if (ctrl_m[0])              e = {8'h00, tb_sio};
    else if (fifo_m.size() == 0) e = 16'h0000;
    else                         e = fifo_m.pop_front();
    bus_read(6'h00, e, nm);
  endtask

  task automatic write_ctrl(input logic [15:0] d);
    bus_write(6'h02, d);
    ctrl_m = d[7:0] & 8'hf7;
    done_m = 1'b0;
  endtask

  task automatic expect_reset_outputs(input string tag);
    expect_sig({tag, "_cs"},   SEL_CS,    32'h3, 32'h3);
    expect_sig({tag, "_sclk"}, SEL_SCLK,  32'h0, 32'h3);
    expect_sig({tag, "_latoe"}, SEL_LATOE, 32'h0, 32'h1);
    expect_sig({tag, "_miso"}, SEL_MISO,  32'h0, 32'h1);
    expect_sig({tag, "_dir"},  SEL_DIR,   32'h0, 32'h1f);
    expect_sig({tag, "_od"},   SEL_OD,    32'h0, 32'h1f);
    sample();
  endtask

  task automatic model_reset();
    fifo_m.delete();
    ctrl_m = 8'h00;
    done_m = 1'b0;
  endtask

  initial begin
    logic [15:0] fixed_words[5];
    logic [15:0] h;
    logic [4:0]  dir, od, outv;
    logic        s[80];
    int          r0, h0, g0, n, hi, lo, last, bad, runs, toggles;
    bit          got;

    rst = 1'b1; mc_oe = 1'b1; mc_ce = 1'b1; mc_we = 1'b1; mc_add = '0;
    tb_data = '0; tb_data_en = 1'b0; tb_sio = '0; tb_sio_en = 1'b0; lat = '0;
    mcu_clock = 1'b0; mcu_mosi = 1'b0; mon_req = 1'b0;
    model_reset();
    tick(4);
    expect_reset_outputs("reset");
    rst = 1'b0;
    tick(2);
    bus_read(6'h02, status_m(), "reset_status");
    read_data("reset_empty_read");

    // FIFO fill to full, drop, ordered drain, empty read.
    fixed_words = '{16'h0055, 16'h0020, 16'h0002, 16'h0303, 16'h1111};
    for (int i = 0; i < 5; i++) begin
      push_data(fixed_words[i]);
      if (i >= 3) bus_read(6'h02, status_m(), $sformatf("fifo_status_after_%0d", i + 1));
    end
    for (int i = 0; i < 5; i++) read_data($sformatf("fifo_pop_%0d", i));

    // Randomised FIFO traffic.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0: push_data(16'($urandom));
        1: read_data($sformatf("rand_pop_%0d", i));
        default: bus_read(6'h02, status_m(), $sformatf("rand_status_%0d", i));
      endcase
    end

    // FIFO head driven onto the SRAM bus.
    push_data(16'($urandom));
    h = fifo_m[0];
    write_ctrl(16'h0002);
    tick(2);
    expect_sig("sram_drive_head", SEL_SIO, 32'(h[7:0]), 32'hff);
    sample();
    write_ctrl(16'h0000);

    // SRAM readback mode: each read returns the bus and fires one clock pulse.
    write_ctrl(16'h0001);
    tb_sio_en = 1'b1;
    foreach (fixed_words[i]) begin
      if (i < 2) begin
        tb_sio = (i == 0) ? 8'hAA : 8'h55;
        r0 = rise_cnt; h0 = high_cyc;
        expect_sig("sram_cs_low", SEL_CS, 32'h0, 32'h3);
        read_data($sformatf("sram_read_%0d", i));
        expect_val("sram_pulse_rises", 32'(rise_cnt - r0), 32'd1);
        expect_val("sram_pulse_width", 32'(high_cyc - h0), 32'd1);
        sample();
      end
    end
    tb_sio_en = 1'b0;
    write_ctrl(16'h0000);
    bus_read(6'h02, status_m(), "status_after_sram");

    // Latch readback and unmapped addresses.
    for (int i = 0; i < 4; i++) begin
      lat = 8'($urandom);
      tick(1);
      bus_read(6'h06, {8'h00, lat}, $sformatf("lat_read_%0d", i));
    end
    foreach (fixed_words[i]) begin
      if (i < 3) begin
        logic [5:0] ua;
        ua = (i == 0) ? 6'h08 : (i == 1) ? 6'h20 : 6'h3f;
        bus_write(ua, 16'($urandom));
        bus_read(ua, 16'h0000, $sformatf("unmapped_0x%0h", ua));
      end
    end
    bus_read(6'h02, status_m(), "status_after_unmapped");

    // LA count of zero must not start a capture.
    bus_write(6'h04, 16'h0000);
    write_ctrl(16'h0008);
    expect_sig("la_zero_latoe", SEL_LATOE, 32'h0, 32'h1);
    sample();
    bus_read(6'h02, status_m(), "la_zero_status");

    // Capture: fixed 16 samples, then random lengths with a redundant start mid-run.
    for (int k = 0; k < 3; k++) begin
      n = (k == 0) ? 16 : $urandom_range(20, 40);
      bus_write(6'h04, 16'(n));
      r0 = rise_cnt; h0 = high_cyc; g0 = oe_gap;
      write_ctrl(16'h0009);
      if (k > 0) bus_write(6'h02, 16'h0009);
      got = 1'b0;
      for (int i = 0; i < 400 && !got; i++) begin
        tick(1);
        got = mcu_miso;
      end
      expect_val("la_done_seen", 32'(got), 32'd1);
      tick(3);
      done_m = 1'b1;
      expect_val($sformatf("la_rises_n%0d", n), 32'(rise_cnt - r0), 32'(n));
      expect_val("la_high_cycles", 32'(high_cyc - h0), 32'(n));
      expect_val("la_latoe_held", 32'(oe_gap - g0), 32'd0);
      expect_sig("la_latoe_off", SEL_LATOE, 32'h0, 32'h1);
      expect_sig("la_miso", SEL_MISO, 32'h1, 32'h1);
      expect_sig("la_cs_follow", SEL_CS, 32'h0, 32'h3);
      sample();
      bus_read(6'h02, status_m(), "la_done_status");
      write_ctrl(16'h0000);
      expect_sig("la_miso_clear", SEL_MISO, 32'h0, 32'h1);
      expect_sig("la_cs_idle", SEL_CS, 32'h3, 32'h3);
      sample();
    end

    // Buffered pins: the fixed pattern, then random dir/od/value.
    bus_write(6'h11, 16'h001f);
    bus_write(6'h12, 16'h0001);
    bus_write(6'h10, 16'h000a);
    tick(2);
    expect_sig("pins_fixed", SEL_IO, 32'h0a, 32'h1f);
    expect_sig("pins_dir", SEL_DIR, 32'h1f, 32'h1f);
    expect_sig("pins_od", SEL_OD, 32'h01, 32'h1f);
    sample();
    bus_read(6'h10, 16'h000a, "pins_readback");
    for (int i = 0; i < 4; i++) begin
      dir = 5'($urandom); od = 5'($urandom); outv = 5'($urandom);
      bus_write(6'h11, 16'(dir));
      bus_write(6'h12, 16'(od));
      bus_write(6'h10, 16'(outv));
      tick(1);
      expect_sig($sformatf("pins_rand_%0d", i), SEL_IO, 32'(outv), 32'(dir & ~(od & outv)));
      expect_sig("pins_rand_dir", SEL_DIR, 32'(dir), 32'h1f);
      sample();
    end

    // PWM on pin 0.
    bus_write(6'h11, 16'h0001);
    bus_write(6'h12, 16'h0000);
    bus_write(6'h10, 16'h0000);
    bus_write(6'h19, 16'h0001);
    bus_write(6'h1a, 16'h0001);
    s[0] = bpio_io[0];
    toggles = 0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      s[i] = bpio_io[0];
      if (s[i] != s[i-1]) toggles++;
    end
    expect_val("pwm_1_1_toggles", 32'(toggles), 32'd10);
    sample();
    for (int k = 0; k < 3; k++) begin
      hi = $urandom_range(1, 5);
      lo = $urandom_range(1, 5);
      bus_write(6'h19, 16'(hi));
      bus_write(6'h1a, 16'(lo));
      for (int i = 0; i < 80; i++) begin
        s[i] = bpio_io[0];
        tick(1);
      end
      last = -1; bad = 0; runs = 0;
      for (int i = 1; i < 80; i++) begin
        if (s[i] != s[i-1]) begin
          if (last >= 0) begin
            if ((s[last] ? hi : lo) != (i - last)) bad++;
            runs++;
          end
          last = i;
        end
      end
      expect_val($sformatf("pwm_runs_h%0d_l%0d", hi, lo), 32'(bad), 32'd0);
      expect_val("pwm_runs_seen", 32'(runs >= 4), 32'd1);
      sample();
    end
    bus_write(6'h1a, 16'h0000);
    bus_write(6'h10, 16'h0001);
    tick(1);
    expect_sig("pwm_off_pin0", SEL_IO, 32'h1, 32'h1);
    sample();

    // Reset in the middle of a capture.
    bus_write(6'h04, 16'd100);
    write_ctrl(16'h0009);
    tick(20);
    expect_sig("mid_capture_latoe", SEL_LATOE, 32'h1, 32'h1);
    sample();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    expect_reset_outputs("abort");
    bus_read(6'h02, status_m(), "abort_status");
    read_data("abort_fifo_empty");

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
